seg_frame_decoder: RTL and testbench
====================================

SEG_FRAME_DECODER -- requirements
Module: seg_frame_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, is the number of consecutive cycles a synchronized (seg,sel) pair is held before capture; legal range is 2..255.
REQ-002 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 seg  input  7  observed segment lines, active LOW, bit order gfedcba (bit6=g, bit0=a).
REQ-005 sel  input  4  observed digit selects, active LOW; sel[i] low selects digit i.
REQ-006 value  output  16  decoded frame; digit i maps to value[4i+3:4i].
REQ-007 digit_valid  output  4  per-digit legality of the last completed frame.
REQ-008 frame_valid  output  1  one-cycle pulse when value/digit_valid update.
REQ-009 frame_err  output  1  one-cycle pulse, coincident with frame_valid, when any digit in the frame was illegal.

Function
REQ-010 seg and sel SHALL each pass through a 2-flop synchronizer before any other use.
REQ-011 A run counter SHALL be 1 on the first cycle a synchronized pair differs from the prior cycle, then increment, saturating at STABLE_CYCLES.
REQ-012 A capture SHALL occur exactly once per dwell, on the cycle the run counter first equals STABLE_CYCLES, and only if synchronized sel has exactly one bit low.
REQ-013 sel all-high or more than one bit low SHALL never capture; the run counter still tracks the pair.
REQ-014 Decode table (seg hex -> nibble): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F.
REQ-015 Any other seg pattern SHALL be captured as illegal: shadow nibble 0, shadow legal bit 0.
REQ-016 Each capture SHALL write the selected digit's shadow nibble and legal bit and set its bit in a 4-bit seen mask.
REQ-017 A recapture of a digit already in the mask SHALL overwrite its shadow; the mask SHALL be unchanged.
REQ-018 On the edge of the capture that makes the mask 1111, value SHALL load all four shadows (including the new capture), digit_valid SHALL load the legal bits, frame_valid SHALL pulse, and the mask SHALL clear.
REQ-019 frame_err SHALL pulse on that same cycle iff any loaded legal bit is 0.
REQ-020 Outside frame completion, value and digit_valid SHALL hold.
REQ-021 Latency from a stable pair at the seg/sel pins to capture visibility SHALL be 2+STABLE_CYCLES cycles.

Reset
REQ-022 rst SHALL clear the synchronizers, run counter, shadows, and mask, and set value=0, digit_valid=0, frame_valid=0, frame_err=0.
REQ-023 rst asserted mid-frame SHALL discard the partial frame; after release the first frame SHALL require four fresh captures.
REQ-024 The first pair after reset SHALL be treated as a change (run=1).

Configuration
REQ-025 With SEG_FRAME_DECODER_DP_EN defined, the block SHALL add input dp (1, active LOW, 2-flop synchronized, part of the stability pair) and output dp_out (4), loaded at frame completion with the per-digit inverted dp captured alongside each digit, reset to 0.
REQ-026 Without SEG_FRAME_DECODER_DP_EN, the dp and dp_out ports and all related logic SHALL be absent and behaviour SHALL be as above.

Verification (STABLE_CYCLES=4)
REQ-027 Hold sel=1110, seg=40, then 1101/79, 1011/24, and 0111/30, 10 cycles each -> frame_valid pulses once, value=0x3210, digit_valid=1111, frame_err=0.
REQ-028 Apply sel=1110, seg=40 at cycle 0 -> capture visible at cycle 6; hold 3 cycles only -> no capture.
REQ-029 Frame with digit 2 seg=7F -> value=0x3010, digit_valid=1011, frame_err and frame_valid pulse together.
REQ-030 Select digit 0 twice (seg 40, then 0E) before digits 1-3 -> exactly one frame_valid, value[3:0]=F.
REQ-031 Hold sel=1100 or sel=1111 for 20 cycles -> no capture, mask unchanged; rst after 3 digits -> outputs 0, next frame needs all 4 digits.
REQ-032 Enable SEG_FRAME_DECODER_DP_EN with dp low on digit 1 only -> dp_out=0010 at frame_valid.

Source files
------------

// File: rtl/seg_frame_decoder.sv
// Decodes a multiplexed 4-digit active-low 7-segment display bus into a 16-bit frame.
// Optional decimal-point capture is enabled with `define SEG_FRAME_DECODER_DP_EN.
module seg_frame_decoder #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  seg,
   input  logic [3:0]  sel,
   output logic [15:0] value,
   output logic [3:0]  digit_valid,
   output logic        frame_valid,
   output logic        frame_err
`ifdef SEG_FRAME_DECODER_DP_EN
   ,
   input  logic        dp,
   output logic [3:0]  dp_out
`endif
);

   localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
`ifdef SEG_FRAME_DECODER_DP_EN
   localparam int PAIR_W = 12;
`else
   localparam int PAIR_W = 11;
`endif

   // Returns {legal, nibble}; unknown patterns decode to an illegal zero.
   function automatic logic [4:0] decode_seg(input logic [6:0] s);
      case (s)
         7'h40: decode_seg = 5'h10;
         7'h79: decode_seg = 5'h11;
         7'h24: decode_seg = 5'h12;
         7'h30: decode_seg = 5'h13;
         7'h19: decode_seg = 5'h14;
         7'h12: decode_seg = 5'h15;
         7'h02: decode_seg = 5'h16;
         7'h78: decode_seg = 5'h17;
         7'h00: decode_seg = 5'h18;
         7'h10: decode_seg = 5'h19;
         7'h08: decode_seg = 5'h1A;
         7'h03: decode_seg = 5'h1B;
         7'h46: decode_seg = 5'h1C;
         7'h21: decode_seg = 5'h1D;
         7'h06: decode_seg = 5'h1E;
         7'h0E: decode_seg = 5'h1F;
         default: decode_seg = 5'h00;
      endcase
   endfunction

   logic [PAIR_W-1:0] pin_pair;
   logic [PAIR_W-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
   logic [7:0]        run_q, run_d;
   logic [15:0]       shadow_nib_q, shadow_nib_d;
   logic [3:0]        shadow_leg_q, shadow_leg_d;
   logic [3:0]        mask_q, mask_d;
   logic [15:0]       value_q, value_d;
   logic [3:0]        digit_valid_q, digit_valid_d;
   logic              frame_valid_q, frame_valid_d;
   logic              frame_err_q, frame_err_d;
   logic [3:0]        sel_now;
   logic [6:0]        seg_now;
   logic [4:0]        dec;
   logic [1:0]        idx;
   logic              one_hot;
   logic              capture;
   logic [3:0]        mask_next;
`ifdef SEG_FRAME_DECODER_DP_EN
   logic [3:0]        shadow_dp_q, shadow_dp_d;
   logic [3:0]        dp_out_q, dp_out_d;

   assign pin_pair = {dp, sel, seg};
`else
   assign pin_pair = {sel, seg};
`endif

   assign sel_now = sync2_q[10:7];
   assign seg_now = sync2_q[6:0];

   always_comb begin
      sync1_d       = pin_pair;
      sync2_d       = sync1_q;
      prev_d        = sync2_q;
      shadow_nib_d  = shadow_nib_q;
      shadow_leg_d  = shadow_leg_q;
      mask_d        = mask_q;
      value_d       = value_q;
      digit_valid_d = digit_valid_q;
      frame_valid_d = 1'b0;
      frame_err_d   = 1'b0;
      mask_next     = mask_q;
      idx           = 2'd0;
      one_hot       = 1'b1;
      dec           = decode_seg(seg_now);
`ifdef SEG_FRAME_DECODER_DP_EN
      shadow_dp_d   = shadow_dp_q;
      dp_out_d      = dp_out_q;
`endif

      // run_q == 0 only right after reset, so the first pair always restarts the run
      if (run_q == 8'd0 || sync2_q != prev_q)
         run_d = 8'd1;
      else if (run_q == STABLE)
         run_d = run_q;
      else
         run_d = run_q + 8'd1;

      case (sel_now)
         4'b1110: idx = 2'd0;
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: one_hot = 1'b0;
      endcase

      capture = (run_d == STABLE) && (run_q != STABLE) && one_hot;

      if (capture) begin
         shadow_nib_d[4*idx +: 4] = dec[3:0];
         shadow_leg_d[idx]        = dec[4];
         mask_next                = mask_q | (4'b0001 << idx);
         mask_d                   = mask_next;
`ifdef SEG_FRAME_DECODER_DP_EN
         shadow_dp_d[idx]         = ~sync2_q[11];
`endif
         // The completing capture is folded into the frame on the same edge
         if (&mask_next) begin
            value_d       = shadow_nib_d;
            digit_valid_d = shadow_leg_d;
            frame_valid_d = 1'b1;
            frame_err_d   = ~&shadow_leg_d;
            mask_d        = 4'b0000;
`ifdef SEG_FRAME_DECODER_DP_EN
            dp_out_d      = shadow_dp_d;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q       <= '0;
         sync2_q       <= '0;
         prev_q        <= '0;
         run_q         <= '0;
         shadow_nib_q  <= '0;
         shadow_leg_q  <= '0;
         mask_q        <= '0;
         value_q       <= '0;
         digit_valid_q <= '0;
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
`ifdef SEG_FRAME_DECODER_DP_EN
         shadow_dp_q   <= '0;
         dp_out_q      <= '0;
`endif
      end else begin
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         prev_q        <= prev_d;
         run_q         <= run_d;
         shadow_nib_q  <= shadow_nib_d;
         shadow_leg_q  <= shadow_leg_d;
         mask_q        <= mask_d;
         value_q       <= value_d;
         digit_valid_q <= digit_valid_d;
         frame_valid_q <= frame_valid_d;
         frame_err_q   <= frame_err_d;
`ifdef SEG_FRAME_DECODER_DP_EN
         shadow_dp_q   <= shadow_dp_d;
         dp_out_q      <= dp_out_d;
`endif
      end
   end

   assign value       = value_q;
   assign digit_valid = digit_valid_q;
   assign frame_valid = frame_valid_q;
   assign frame_err   = frame_err_q;
`ifdef SEG_FRAME_DECODER_DP_EN
   assign dp_out      = dp_out_q;
`endif

endmodule

// File: tb/tb_seg_frame_decoder.sv
// Bench for seg_frame_decoder: per-cycle comparison against a sample-history model,
// plus literal frame results. Build with SEG_FRAME_DECODER_DP_EN to cover dp.
module tb_seg_frame_decoder;

   localparam int STABLE = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [6:0]  seg_i = 7'h7F;
   logic [3:0]  sel_i = 4'hF;
   logic        dp_i = 1'b1;
   logic [15:0] value;
   logic [3:0]  digit_valid;
   logic        frame_valid;
   logic        frame_err;
`ifdef SEG_FRAME_DECODER_DP_EN
   logic [3:0]  dp_out;
`endif

   int n_vec  = 0;
   int n_miss = 0;

   seg_frame_decoder #(.STABLE_CYCLES(STABLE)) dut (
      .clk         (clk),
      .rst         (rst),
      .seg         (seg_i),
      .sel         (sel_i),
      .value       (value),
      .digit_valid (digit_valid),
      .frame_valid (frame_valid),
      .frame_err   (frame_err)
`ifdef SEG_FRAME_DECODER_DP_EN
      ,
      .dp          (dp_i),
      .dp_out      (dp_out)
`endif
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [11:0] dl0, dl1;
   logic [11:0] hist[$];
   logic [3:0]  m_nib [4];
   logic        m_leg [4];
   logic        m_seen[4];
   logic        m_dp  [4];
   logic [15:0] exp_value;
   logic [3:0]  exp_dv, exp_dp;
   logic        exp_fv, exp_fe;
   bit          model_live = 0;

   always @(posedge clk) begin
      model_live = 1;
      if (rst) begin
         dl0 = '0; dl1 = '0; hist.delete();
         for (int i = 0; i < 4; i++) begin
            m_nib[i] = 0; m_leg[i] = 0; m_seen[i] = 0; m_dp[i] = 0;
         end
         exp_value = 0; exp_dv = 0; exp_dp = 0; exp_fv = 0; exp_fe = 0;
      end else begin
         logic [11:0] cur;
         logic [3:0]  nsel;
         int run, d, hit;
         cur = dl1; dl1 = dl0; dl0 = {dp_i, sel_i, seg_i};
         hist.push_back(cur);
         if (hist.size() > STABLE + 1) void'(hist.pop_front());
         run = 0;
         for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] == cur) run++;
            else break;
         end
         exp_fv = 0; exp_fe = 0;
         nsel = ~cur[10:7];
         if (run == STABLE && $countones(nsel) == 1) begin
            d = 0;
            for (int i = 0; i < 4; i++) if (nsel[i]) d = i;
            hit = -1;
            for (int k = 0; k < 16; k++) if (seg_tab[k] == cur[6:0]) hit = k;
            m_nib[d]  = (hit >= 0) ? 4'(hit) : 4'd0;
            m_leg[d]  = (hit >= 0);
            m_dp[d]   = ~cur[11];
            m_seen[d] = 1;
            if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
               exp_value = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
               exp_dv    = {m_leg[3], m_leg[2], m_leg[1], m_leg[0]};
               exp_dp    = {m_dp[3], m_dp[2], m_dp[1], m_dp[0]};
               exp_fv    = 1;
               exp_fe    = !(m_leg[0] && m_leg[1] && m_leg[2] && m_leg[3]);
               for (int i = 0; i < 4; i++) m_seen[i] = 0;
            end
         end
      end
   end

   // ---------------- per-cycle compare and frame monitor ----------------
   int          fv_count = 0;
   logic        last_fe  = 0;

   always @(negedge clk) begin
      if (model_live) begin
         n_vec++;
         if (value !== exp_value || digit_valid !== exp_dv ||
             frame_valid !== exp_fv || frame_err !== exp_fe) begin
            n_miss++;
            $display("FAIL cycle_cmp t=%0t got value=%h dv=%b fv=%b fe=%b want value=%h dv=%b fv=%b fe=%b",
                     $time, value, digit_valid, frame_valid, frame_err,
                     exp_value, exp_dv, exp_fv, exp_fe);
         end
`ifdef SEG_FRAME_DECODER_DP_EN
         n_vec++;
         if (dp_out !== exp_dp) begin
            n_miss++;
            $display("FAIL dp_cmp t=%0t got %b want %b", $time, dp_out, exp_dp);
         end
`endif
         if (frame_valid === 1'b1) begin
            fv_count++;
            last_fe = frame_err;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_miss++;
         $display("FAIL %s got %h want %h", name, act, req);
      end
   endtask

   task automatic hold(input logic [3:0] s, input logic [6:0] g, input int n);
      sel_i = s; seg_i = g;
      repeat (n) @(negedge clk);
   endtask

   task automatic frame4(input logic [6:0] g0, input logic [6:0] g1,
                         input logic [6:0] g2, input logic [6:0] g3);
      hold(4'b1110, g0, 10);
      hold(4'b1101, g1, 10);
      hold(4'b1011, g2, 10);
      hold(4'b0111, g3, 10);
   endtask

   initial begin
      int c0, lat;
      repeat (3) @(negedge clk);
      rst = 0;
      check("reset_value", 32'(value), 32'h0);
      check("reset_dv", 32'(digit_valid), 32'h0);
      check("reset_fv_fe", {30'd0, frame_valid, frame_err}, 32'h0);

      // Basic frame 3210
      c0 = fv_count;
      frame4(7'h40, 7'h79, 7'h24, 7'h30);
      check("basic_fv_count", 32'(fv_count - c0), 32'd1);
      check("basic_value", 32'(value), 32'h3210);
      check("basic_dv", 32'(digit_valid), 32'hF);
      check("basic_fe", 32'(last_fe), 32'd0);

      // Illegal digit 2
      c0 = fv_count;
      frame4(7'h40, 7'h79, 7'h7F, 7'h30);
      check("illegal_fv_count", 32'(fv_count - c0), 32'd1);
      check("illegal_value", 32'(value), 32'h3010);
      check("illegal_dv", 32'(digit_valid), 32'hB);
      check("illegal_fe", 32'(last_fe), 32'd1);

      // Recapture of digit 0
      c0 = fv_count;
      hold(4'b1110, 7'h40, 10);
      hold(4'b1110, 7'h0E, 10);
      hold(4'b1101, 7'h79, 10);
      hold(4'b1011, 7'h24, 10);
      hold(4'b0111, 7'h30, 10);
      check("recap_fv_count", 32'(fv_count - c0), 32'd1);
      check("recap_value", 32'(value), 32'h321F);

      // Too-short dwell, then latency of a real capture
      c0 = fv_count;
      hold(4'b1110, 7'h40, 3);
      hold(4'b1111, 7'h7F, 10);
      hold(4'b1101, 7'h79, 10);
      hold(4'b1011, 7'h24, 10);
      hold(4'b0111, 7'h30, 10);
      check("short_dwell_no_frame", 32'(fv_count - c0), 32'd0);
      sel_i = 4'b1110; seg_i = 7'h19;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (frame_valid === 1'b1) begin
            lat = i;
            break;
         end
      end
      check("capture_latency", 32'(lat), 32'd6);
      check("latency_value", 32'(value), 32'h3214);

      // Non-one-hot selects leave the mask alone
      hold(4'b1111, 7'h7F, 10);
      c0 = fv_count;
      hold(4'b1110, 7'h40, 10);
      hold(4'b1101, 7'h79, 10);
      hold(4'b1011, 7'h24, 10);
      hold(4'b1100, 7'h40, 20);
      hold(4'b1111, 7'h40, 20);
      check("multi_sel_no_frame", 32'(fv_count - c0), 32'd0);
      hold(4'b0111, 7'h30, 10);
      check("mask_kept_fv_count", 32'(fv_count - c0), 32'd1);
      check("mask_kept_value", 32'(value), 32'h3210);

      // Reset mid-frame discards the partial frame
      hold(4'b1110, 7'h12, 10);
      hold(4'b1101, 7'h02, 10);
      hold(4'b1011, 7'h78, 10);
      rst = 1;
      repeat (2) @(negedge clk);
      rst = 0;
      check("midrst_value", 32'(value), 32'h0);
      check("midrst_dv", 32'(digit_valid), 32'h0);
      c0 = fv_count;
      hold(4'b1111, 7'h7F, 10);
      hold(4'b1101, 7'h79, 10);
      hold(4'b1011, 7'h24, 10);
      hold(4'b0111, 7'h30, 10);
      check("midrst_three_no_frame", 32'(fv_count - c0), 32'd0);
      hold(4'b1110, 7'h46, 10);
      check("midrst_fourth_frame", 32'(fv_count - c0), 32'd1);
      check("midrst_value_after", 32'(value), 32'h321C);

`ifdef SEG_FRAME_DECODER_DP_EN
      // Decimal point on digit 1 only
      c0 = fv_count;
      hold(4'b1110, 7'h40, 10);
      dp_i = 0;
      hold(4'b1101, 7'h79, 10);
      dp_i = 1;
      hold(4'b1011, 7'h24, 10);
      hold(4'b0111, 7'h30, 10);
      check("dp_fv_count", 32'(fv_count - c0), 32'd1);
      check("dp_out", 32'(dp_out), 32'h2);
`endif

      hold(4'b1111, 7'h7F, 5);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
